// File: rtl/hack_soc_pkg.sv
// Shared types and constants for the hack_soc ROM loading path.
// Used by the ROM loader FSM and its SPI frame shifter.
package hack_soc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        ACK
    } loader_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_LOW,
        TX_HIGH
    } tx_state_t;

    localparam logic [7:0] ROM_WRITE_CMD  = 8'h02;
    localparam int         SPI_FRAME_BITS = 48;

endpackage

// File: rtl/rom_loader_sram_writer_spi_frame_tx.sv
// Single-bit SPI mode-0 shifter: sends one frame MSB first, two clocks per bit,
// after a one-cycle setup slot that lines up with the loader's SETUP state.
module spi_frame_tx
    import hack_soc_pkg::*;
#(
    parameter int FRAME_BITS = SPI_FRAME_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [FRAME_BITS-1:0] frame_i,
    output logic                  done_o,
    output logic                  sck_o,
    output logic                  sio0_o
);

    localparam int CNT_W = $clog2(FRAME_BITS);

    tx_state_t             state_q;
    logic [CNT_W-1:0]      bitCnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  sck_q;

    // The outgoing bit is always the shift register MSB; it only moves while sck falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= TX_IDLE;
            bitCnt_q <= '0;
            shift_q  <= '0;
            sck_q    <= 1'b0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    sck_q <= 1'b0;
                    if (start_i) begin
                        shift_q  <= frame_i;
                        bitCnt_q <= CNT_W'(FRAME_BITS - 1);
                        state_q  <= TX_SETUP;
                    end
                end
                TX_SETUP: begin
                    state_q <= TX_LOW;
                end
                TX_LOW: begin
                    sck_q   <= 1'b1;
                    state_q <= TX_HIGH;
                end
                TX_HIGH: begin
                    sck_q <= 1'b0;
                    if (bitCnt_q == '0) begin
                        shift_q <= '0;
                        state_q <= TX_IDLE;
                    end else begin
                        bitCnt_q <= bitCnt_q - CNT_W'(1);
                        shift_q  <= {shift_q[FRAME_BITS-2:0], 1'b0};
                        state_q  <= TX_LOW;
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign done_o = (state_q == TX_HIGH) && (bitCnt_q == '0);
    assign sck_o  = sck_q;
    assign sio0_o = shift_q[FRAME_BITS-1];

endmodule

// File: rtl/rom_loader_sram_writer.sv
// Host-to-SRAM ROM loader: takes one word per four-phase handshake and writes it
// to the 23LC1024 with a WRITE command at consecutive word addresses.
module rom_loader_sram_writer
    import hack_soc_pkg::*;
#(
    parameter int         DATA_WIDTH      = 16,
    parameter int         WORD_ADDR_WIDTH = 16,
    parameter int         SRAM_ADDR_BITS  = 24,
    parameter logic [7:0] WRITE_CMD       = ROM_WRITE_CMD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rom_loader_reset,
    input  logic                       rom_loader_load,
    input  logic [DATA_WIDTH-1:0]      rom_loader_data,
    output logic                       rom_loader_ack,
    output logic                       rom_loader_load_received,
    output logic                       loading,
    output logic [WORD_ADDR_WIDTH-1:0] word_addr,
    output logic                       rom_cs_n,
    output logic                       rom_sck,
    output logic                       rom_sio_oe,
    output logic                       rom_sio0_o,
    output logic                       rom_sio1_o,
    output logic                       rom_sio2_o,
    output logic                       rom_sio3_o
);

    localparam int FRAME_BITS = 8 + SRAM_ADDR_BITS + DATA_WIDTH;

    loader_state_t              state_q;
    logic                       sessPrev_q;
    logic                       restart_q;
    logic [WORD_ADDR_WIDTH-1:0] wordAddr_q;
    logic                       ack_q;
    logic                       loadRecv_q;
    logic                       csN_q;
    logic                       sioOe_q;

    logic                       sessRise_d;
    logic                       txStart_d;
    logic                       txDone_d;
    logic [WORD_ADDR_WIDTH-1:0] frameAddr_d;
    logic [SRAM_ADDR_BITS-1:0]  addrField_d;
    logic [FRAME_BITS-1:0]      frame_d;

    // A session rising in the same cycle as the first load must already target word 0.
    assign sessRise_d  = rom_loader_reset & ~sessPrev_q;
    assign frameAddr_d = sessRise_d ? '0 : wordAddr_q;
    assign addrField_d = SRAM_ADDR_BITS'({frameAddr_d, 1'b0});
    assign frame_d     = {WRITE_CMD, addrField_d, rom_loader_data};
    assign txStart_d   = (state_q == IDLE) && rom_loader_reset && rom_loader_load;

    spi_frame_tx #(
        .FRAME_BITS (FRAME_BITS)
    ) u_tx (
        .clk     (clk),
        .reset   (reset),
        .start_i (txStart_d),
        .frame_i (frame_d),
        .done_o  (txDone_d),
        .sck_o   (rom_sck),
        .sio0_o  (rom_sio0_o)
    );

    // A session restart seen mid-word is remembered and applied when the word retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sessPrev_q <= 1'b0;
            restart_q  <= 1'b0;
            wordAddr_q <= '0;
            ack_q      <= 1'b0;
            loadRecv_q <= 1'b0;
            csN_q      <= 1'b1;
            sioOe_q    <= 1'b0;
        end else begin
            sessPrev_q <= rom_loader_reset;
            if ((state_q != IDLE) && sessRise_d) begin
                restart_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    restart_q <= 1'b0;
                    if (sessRise_d) begin
                        wordAddr_q <= '0;
                    end
                    if (txStart_d) begin
                        loadRecv_q <= 1'b1;
                        csN_q      <= 1'b0;
                        sioOe_q    <= 1'b1;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (txDone_d) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    ack_q   <= 1'b1;
                    csN_q   <= 1'b1;
                    sioOe_q <= 1'b0;
                    state_q <= ACK;
                end
                ACK: begin
                    if (!rom_loader_load) begin
                        ack_q      <= 1'b0;
                        loadRecv_q <= 1'b0;
                        restart_q  <= 1'b0;
                        wordAddr_q <= (restart_q || sessRise_d) ? '0
                                    : wordAddr_q + WORD_ADDR_WIDTH'(1);
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rom_loader_ack           = ack_q;
    assign rom_loader_load_received = loadRecv_q;
    assign loading                  = rom_loader_reset | (state_q != IDLE);
    assign word_addr                = wordAddr_q;
    assign rom_cs_n                 = csN_q;
    assign rom_sio_oe               = sioOe_q;
    assign rom_sio1_o               = 1'b0;
    assign rom_sio2_o               = 1'b0;
    assign rom_sio3_o               = 1'b1;

endmodule

// File: tb/tb_rom_loader_sram_writer.sv
// Scoreboarded bench for the ROM loader: an SPI SRAM model decodes frames off the
// pins and each scenario task compares them against frames it queued itself.
module tb_rom_loader_sram_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        romSess = 1'b0;
    logic        romLoad = 1'b0;
    logic [15:0] romData = 16'h0000;
    logic        romAck, romLoadRecv, loading;
    logic [15:0] wordAddr;
    logic        romCsN, romSck, romSioOe;
    logic        sio0, sio1, sio2, sio3;

    int tests = 0;
    int fails = 0;

    logic [47:0] expQ[$];
    logic [47:0] obsQ[$];
    logic [7:0]  sram [logic [23:0]];
    logic [47:0] shiftIn = '0;
    int          bitCnt = 0;

    rom_loader_sram_writer dut (
        .clk                      (clk),
        .reset                    (reset),
        .rom_loader_reset         (romSess),
        .rom_loader_load          (romLoad),
        .rom_loader_data          (romData),
        .rom_loader_ack           (romAck),
        .rom_loader_load_received (romLoadRecv),
        .loading                  (loading),
        .word_addr                (wordAddr),
        .rom_cs_n                 (romCsN),
        .rom_sck                  (romSck),
        .rom_sio_oe               (romSioOe),
        .rom_sio0_o               (sio0),
        .rom_sio1_o               (sio1),
        .rom_sio2_o               (sio2),
        .rom_sio3_o               (sio3)
    );

    always #5 clk = ~clk;

    // SRAM model: samples SI on sck rise, commits a WRITE when CS rises after 48 bits
    always @(posedge romSck or posedge romCsN) begin
        if (romCsN) begin
            if (bitCnt == 48) begin
                obsQ.push_back(shiftIn);
                if (shiftIn[47:40] == 8'h02) begin
                    sram[shiftIn[39:16]]         = shiftIn[15:8];
                    sram[shiftIn[39:16] + 24'd1] = shiftIn[7:0];
                end
            end
            bitCnt = 0;
        end else begin
            shiftIn = {shiftIn[46:0], sio0};
            bitCnt++;
        end
    end

    function automatic logic [47:0] expFrame(input logic [15:0] addr, input logic [15:0] data);
        return {8'h02, 7'b0, addr, 1'b0, data};
    endfunction

    task automatic doReset();
        reset   = 1'b1;
        romLoad = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic startSession();
        romSess = 1'b0;
        @(negedge clk);
        romSess = 1'b1;
        @(negedge clk);
    endtask

    task automatic driveWord(input logic [15:0] data, output int ackCycle);
        romLoad  = 1'b1;
        romData  = data;
        ackCycle = -1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (romAck === 1'b1) begin
                ackCycle = k;
                break;
            end
        end
        romLoad = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        romSess = 1'b0;
        doReset();
        tests++;
        if ({romCsN, romSck, romSioOe, sio0, sio1, sio2, sio3} !== 7'b1000001) begin
            fails++;
            $display("[TB] FAIL reset_pins: got %b expected 1000001",
                     {romCsN, romSck, romSioOe, sio0, sio1, sio2, sio3});
        end
        tests++;
        if ({romAck, romLoadRecv, loading} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL reset_handshake: got %b expected 000", {romAck, romLoadRecv, loading});
        end
        tests++;
        if (wordAddr !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL reset_addr: got %h expected 0000", wordAddr);
        end
    endtask

    task automatic test_single_word();
        logic [47:0] e, o;
        doReset();
        startSession();
        expQ.push_back(expFrame(16'h0000, 16'hABCD));
        romLoad = 1'b1;
        romData = 16'hABCD;
        for (int k = 1; k <= 99; k++) begin
            @(negedge clk);
            if (k == 1) begin
                tests++;
                if ({romLoadRecv, romCsN} !== 2'b10) begin
                    fails++;
                    $display("[TB] FAIL single_t1: got recv,cs_n=%b expected 10", {romLoadRecv, romCsN});
                end
            end
            if (k == 2 || k == 3) begin
                tests++;
                if (romSck !== (k == 3)) begin
                    fails++;
                    $display("[TB] FAIL single_sck_t%0d: got %b expected %b", k, romSck, (k == 3));
                end
            end
            if (k == 98 || k == 99) begin
                tests++;
                if ({romAck, romCsN} !== {2{k == 99}}) begin
                    fails++;
                    $display("[TB] FAIL single_ack_t%0d: got ack,cs_n=%b expected %b", k,
                             {romAck, romCsN}, {2{k == 99}});
                end
            end
        end
        romLoad = 1'b0;
        @(negedge clk);
        tests++;
        if ({romAck, romLoadRecv, wordAddr} !== {2'b00, 16'h0001}) begin
            fails++;
            $display("[TB] FAIL single_retire: got ack,recv,addr=%b,%b,%h expected 0,0,0001",
                     romAck, romLoadRecv, wordAddr);
        end
        e = expQ.pop_front();
        tests++;
        if (obsQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL single_frame: got none expected %h", e);
        end else begin
            o = obsQ.pop_front();
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL single_frame: got %h expected %h", o, e);
            end
        end
        tests++;
        if ({sram[24'h0], sram[24'h1]} !== 16'hABCD) begin
            fails++;
            $display("[TB] FAIL single_sram: got %h expected abcd", {sram[24'h0], sram[24'h1]});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3] = '{16'h1111, 16'h2222, 16'h3333};
        logic [47:0] e, o;
        int          ac;
        doReset();
        startSession();
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(expFrame(16'(i), words[i]));
            driveWord(words[i], ac);
            tests++;
            if (ac !== 99) begin
                fails++;
                $display("[TB] FAIL b2b_ack_latency%0d: got %0d expected 99", i, ac);
            end
        end
        tests++;
        if (wordAddr !== 16'h0003) begin
            fails++;
            $display("[TB] FAIL b2b_addr: got %h expected 0003", wordAddr);
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            tests++;
            if (obsQ.size() == 0) begin
                fails++;
                $display("[TB] FAIL b2b_frame: got none expected %h", e);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("[TB] FAIL b2b_frame: got %h expected %h", o, e);
                end
            end
        end
        tests++;
        if ({sram[24'h0], sram[24'h1], sram[24'h2], sram[24'h3], sram[24'h4], sram[24'h5]}
                !== 48'h111122223333) begin
            fails++;
            $display("[TB] FAIL b2b_sram: got %h expected 111122223333",
                     {sram[24'h0], sram[24'h1], sram[24'h2], sram[24'h3], sram[24'h4], sram[24'h5]});
        end
    endtask

    task automatic test_no_session();
        bit csBad = 1'b0;
        bit respBad = 1'b0;
        romSess = 1'b0;
        doReset();
        romLoad = 1'b1;
        romData = 16'hDEAD;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (romCsN !== 1'b1) csBad = 1'b1;
            if ({romAck, romLoadRecv, loading} !== 3'b000) respBad = 1'b1;
        end
        romLoad = 1'b0;
        @(negedge clk);
        tests++;
        if (csBad || respBad) begin
            fails++;
            $display("[TB] FAIL nosess_ignored: got csBad=%0b respBad=%0b expected 0,0", csBad, respBad);
        end
        tests++;
        if (obsQ.size() !== 0) begin
            fails++;
            $display("[TB] FAIL nosess_frames: got %0d frames expected 0", obsQ.size());
        end
    endtask

    task automatic test_early_drop();
        logic [47:0] e, o;
        bit csBad = 1'b0;
        doReset();
        startSession();
        expQ.push_back(expFrame(16'h0000, 16'h1234));
        romLoad = 1'b1;
        romData = 16'h1234;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k <= 98 && romCsN !== 1'b0) csBad = 1'b1;
            if (k == 5) romData = 16'hFFFF;
            if (k == 10) romLoad = 1'b0;
            if (k == 99) begin
                tests++;
                if ({romAck, romCsN} !== 2'b11) begin
                    fails++;
                    $display("[TB] FAIL early_ack_t99: got %b expected 11", {romAck, romCsN});
                end
            end
            if (k == 100) begin
                tests++;
                if ({romAck, wordAddr} !== {1'b0, 16'h0001}) begin
                    fails++;
                    $display("[TB] FAIL early_ack_pulse: got ack=%b addr=%h expected 0,0001", romAck, wordAddr);
                end
            end
        end
        tests++;
        if (csBad) begin
            fails++;
            $display("[TB] FAIL early_cs_low: got cs_n high before T+99 expected low");
        end
        e = expQ.pop_front();
        tests++;
        if (obsQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL early_frame: got none expected %h", e);
        end else begin
            o = obsQ.pop_front();
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL early_frame: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [47:0] e, o;
        int          ac;
        doReset();
        startSession();
        expQ.push_back(expFrame(16'h0000, 16'h4444));
        driveWord(16'h4444, ac);
        romLoad = 1'b1;
        romData = 16'h7777;
        for (int k = 1; k <= 50; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({romCsN, romSck, romSioOe, romAck, romLoadRecv, wordAddr} !== {5'b10000, 16'h0000}) begin
            fails++;
            $display("[TB] FAIL rstmid_outputs: got cs,sck,oe,ack,recv=%b addr=%h expected 10000,0000",
                     {romCsN, romSck, romSioOe, romAck, romLoadRecv}, wordAddr);
        end
        reset   = 1'b0;
        romLoad = 1'b0;
        @(negedge clk);
        startSession();
        expQ.push_back(expFrame(16'h0000, 16'h8888));
        driveWord(16'h8888, ac);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            tests++;
            if (obsQ.size() == 0) begin
                fails++;
                $display("[TB] FAIL rstmid_frame: got none expected %h", e);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("[TB] FAIL rstmid_frame: got %h expected %h", o, e);
                end
            end
        end
    endtask

    task automatic test_session_restart();
        logic [47:0] e, o;
        int          ac;
        doReset();
        startSession();
        expQ.push_back(expFrame(16'h0000, 16'hA001));
        driveWord(16'hA001, ac);
        expQ.push_back(expFrame(16'h0001, 16'hA002));
        driveWord(16'hA002, ac);
        romSess = 1'b0;
        repeat (2) @(negedge clk);
        romSess = 1'b1;
        @(negedge clk);
        tests++;
        if (wordAddr !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL restart_addr: got %h expected 0000", wordAddr);
        end
        expQ.push_back(expFrame(16'h0000, 16'hA003));
        driveWord(16'hA003, ac);
        // Restart mid-transfer: the frame keeps address 1, the counter returns to 0.
        expQ.push_back(expFrame(16'h0001, 16'hA004));
        romLoad = 1'b1;
        romData = 16'hA004;
        for (int k = 1; k <= 99; k++) begin
            @(negedge clk);
            if (k == 20) romSess = 1'b0;
            if (k == 25) begin
                tests++;
                if ({loading, romCsN} !== 2'b10) begin
                    fails++;
                    $display("[TB] FAIL restart_mid_loading: got loading,cs_n=%b expected 10", {loading, romCsN});
                end
            end
            if (k == 30) romSess = 1'b1;
        end
        romLoad = 1'b0;
        @(negedge clk);
        tests++;
        if (wordAddr !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL restart_mid_addr: got %h expected 0000", wordAddr);
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            tests++;
            if (obsQ.size() == 0) begin
                fails++;
                $display("[TB] FAIL restart_frame: got none expected %h", e);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("[TB] FAIL restart_frame: got %h expected %h", o, e);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [47:0] e, o;
        int          ac;
        doReset();
        startSession();
        force dut.wordAddr_q = 16'hFFFF;
        @(negedge clk);
        release dut.wordAddr_q;
        @(negedge clk);
        expQ.push_back(expFrame(16'hFFFF, 16'h5AA5));
        driveWord(16'h5AA5, ac);
        tests++;
        if (ac !== 99 || wordAddr !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL wrap_addr: got ack@%0d addr=%h expected 99,0000", ac, wordAddr);
        end
        e = expQ.pop_front();
        tests++;
        if (obsQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL wrap_frame: got none expected %h", e);
        end else begin
            o = obsQ.pop_front();
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL wrap_frame: got %h expected %h", o, e);
            end
        end
        tests++;
        if ({sram[24'h1FFFE], sram[24'h1FFFF]} !== 16'h5AA5) begin
            fails++;
            $display("[TB] FAIL wrap_sram: got %h expected 5aa5", {sram[24'h1FFFE], sram[24'h1FFFF]});
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_no_session();
        test_early_drop();
        test_reset_mid();
        test_session_restart();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
